// File: rtl/prog_loader.sv
// Host byte-stream loader: assembles 16-bit words into the instruction RAM,
// verifies an XOR checksum, then starts the CPU and serves its fetches.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_datain,
  output logic              cpu_enable,
  output logic              cpu_start,
  input  logic              stop_req,
  input  logic              clr_err,
  output logic              busy,
  output logic              chk_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE, HI, LO, CHK, START, RUN, ERR
  } state_t;

  state_t state, state_nx;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   words_cnt;
  logic [ADDR_W:0]   len_n;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        chk;
  logic [7:0]        hi_reg;
  logic              xfer;
  logic              we;

  assign rx_ready = (state == IDLE) || (state == HI)
                 || (state == LO) || (state == CHK);
  assign xfer = rx_valid && rx_ready;
  assign we   = xfer && (state == LO) && !reset;

  // LEN of zero encodes a full 256-word image
  assign len_n = (rx_data == 8'd0) ? (ADDR_W+1)'(DEPTH)
                                   : (ADDR_W+1)'(rx_data);

  assign cpu_start    = (state == START);
  assign cpu_enable   = (state == START) || (state == RUN);
  assign chk_err      = (state == ERR);
  assign busy         = (state != IDLE);
  assign words_loaded = words_cnt;
  assign i_datain     = mem[i_addr];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (xfer) state_nx = HI;
      HI:    if (xfer) state_nx = LO;
      LO:    if (xfer) state_nx = (remaining == 1) ? CHK : HI;
      CHK:   if (xfer) state_nx = (rx_data == chk) ? START : ERR;
      START: state_nx = RUN;
      RUN:   if (stop_req) state_nx = IDLE;
      ERR:   if (clr_err) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      remaining <= '0;
      words_cnt <= '0;
      wr_addr   <= '0;
      chk       <= '0;
      hi_reg    <= '0;
    end else if (xfer) begin
      unique case (state)
        IDLE: begin
          remaining <= len_n;
          wr_addr   <= '0;
          chk       <= rx_data;
          words_cnt <= '0;
        end
        HI: begin
          hi_reg <= rx_data;
          chk    <= chk ^ rx_data;
        end
        LO: begin
          chk       <= chk ^ rx_data;
          wr_addr   <= wr_addr + 1'b1;
          words_cnt <= words_cnt + 1'b1;
          remaining <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RAM is deliberately left out of reset so a reset keeps the image
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= {hi_reg, rx_data};
  end

endmodule
